charge_ctrl: RTL and testbench
==============================

CHARGE_CTRL -- requirements
Module: charge_ctrl

Interface
REQ-001 Parameter CHG_W, default 8: width of the charge output and fee arithmetic.
REQ-002 Parameter UNIT_FEE, default 1: fee added per unit_pulse in UNIT mode.
REQ-003 Parameter MAX_UNITS, default 15: unit count that auto-finishes UNIT mode.
REQ-004 Parameter TICK_DIV, default 100000: clk cycles per time tick in TIME mode, minimum 2.
REQ-005 Parameter TIME_FEE, default 1: fee per elapsed tick in TIME mode on cancel.
REQ-006 Parameter BASE_FEE, default 10: fee added to the elapsed-time fee on cancel in TIME mode.
REQ-007 Parameters PLAN1_FEE and PLAN2_FEE, defaults 12 and 5: fixed tariffs for plan1 and plan2.
REQ-008 Port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-009 Port reset, input, 1: synchronous reset, active-high.
REQ-010 Ports start, signal, sel_unit, sel_time, unit_pulse, plan1, plan2, cancel, input, 1 each: request strobes, sampled every clk.
REQ-011 Port work, output, 1: station powered and active.
REQ-012 Port hold_in, output, 1: a session is open.
REQ-013 Port mode, output, 2: 00 none, 01 UNIT, 10 TIME.
REQ-014 Port state, output, 3: current FSM state encoding.
REQ-015 Port charge, output, CHG_W: fee of the last or current session.
REQ-016 Port fin, output, 1: one-cycle pulse when a session completes.

Function
REQ-017 FSM states shall be IDLE=0, READY=1, SELECT=2, CHARGE=3, DONE=4; all transitions are registered with 1-cycle latency.
REQ-018 IDLE: start -> READY with work=1.
REQ-019 READY: signal -> SELECT with hold_in=1 and charge cleared to 0.
REQ-020 SELECT: priority order is sel_unit (-> CHARGE, mode=01), then sel_time (-> CHARGE, mode=10, tick counters cleared), then cancel (-> READY, hold_in=0).
REQ-021 CHARGE/UNIT: each cycle with unit_pulse increments the unit count; charge = units*UNIT_FEE, saturating at 2^CHG_W-1.
REQ-022 CHARGE/UNIT exit: cancel, or a pulse that brings units to MAX_UNITS, -> DONE; cancel and unit_pulse in the same cycle count the pulse first.
REQ-023 CHARGE/TIME timing: a prescaler counts to TICK_DIV-1 and then increments elapsed ticks; elapsed saturates at its maximum.
REQ-024 CHARGE/TIME exit priority: cancel (charge = BASE_FEE + elapsed*TIME_FEE, saturating), then plan1 (charge = PLAN1_FEE), then plan2 (charge = PLAN2_FEE); each -> DONE.
REQ-025 DONE: fin=1 for exactly that one cycle, hold_in=0, mode=00; next cycle -> READY; charge holds until the next READY->SELECT transition.
REQ-026 All fee arithmetic shall use at least CHG_W+1 bits internally before clamping; charge shall never wrap.
REQ-027 Any request strobe not listed for the current state shall be ignored.

Reset
REQ-028 reset shall take priority over all other inputs; the next state is IDLE with work=0, hold_in=0, mode=00, charge=0, fin=0, and all counters 0.
REQ-029 Reset in any state, including mid-CHARGE, shall discard the session without a fin pulse.

Configuration
REQ-030 With CHARGE_TIMEOUT_EN defined, SELECT shall return to READY (hold_in=0) after TIMEOUT_TICKS (parameter, default 30) ticks with no selection; without it, SELECT waits indefinitely and the parameter is unused.

Structure
REQ-031 Package charge_pkg shall hold the state enum, the mode enum (NONE, UNIT, TIME), and the default fee constants.
REQ-032 The prescaler shall be the sub-module charge_tick (clk, reset, clr, tick output), reused for the TIME mode and for the timeout.

Verification
REQ-033 reset, start, signal, sel_unit, 3 unit_pulse, cancel -> charge=3, single-cycle fin, then state=READY.
REQ-034 UNIT mode with MAX_UNITS=15 and 15 pulses -> auto DONE, charge=15, and no cancel needed.
REQ-035 TIME mode with TICK_DIV=4 and 5 ticks elapsed, then cancel -> charge=15; separately plan1 -> 12 and plan2 -> 5.
REQ-036 Saturation: CHG_W=4, UNIT_FEE=3, 6 pulses -> charge=15 and does not wrap.
REQ-037 reset asserted mid-CHARGE -> next cycle state=IDLE, all outputs 0, and no fin pulse.
REQ-038 With CHARGE_TIMEOUT_EN, TIMEOUT_TICKS=2, TICK_DIV=4, idle in SELECT -> READY after 8 cycles with hold_in=0.

Source files
------------

// File: rtl/charge_pkg.sv
// Shared types and default tariffs for the charging-station controller.
// The optional SELECT timeout is enabled by defining CHARGE_TIMEOUT_EN.
package charge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_SELECT = 3'd2,
    ST_CHARGE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_UNIT = 2'd1,
    MODE_TIME = 2'd2
  } mode_t;

  localparam int DEF_CHG_W         = 8;
  localparam int DEF_UNIT_FEE      = 1;
  localparam int DEF_MAX_UNITS     = 15;
  localparam int DEF_TICK_DIV      = 100000;
  localparam int DEF_TIME_FEE      = 1;
  localparam int DEF_BASE_FEE      = 10;
  localparam int DEF_PLAN1_FEE     = 12;
  localparam int DEF_PLAN2_FEE     = 5;
  localparam int DEF_TIMEOUT_TICKS = 30;

endpackage

// File: rtl/charge_tick.sv
// Free-running prescaler: pulses tick for one cycle every TICK_DIV clocks
// while clr is low; clr forces the count back to zero and suppresses tick.
module charge_tick
  import charge_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST) && !clr;

  // Next count: clear on request, wrap at the last value, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/charge_ctrl.sv
// Charging-station session controller: IDLE -> READY -> SELECT -> CHARGE
// (per-unit or timed tariff) -> DONE. All outputs come straight from flops.
// Define CHARGE_TIMEOUT_EN to let an idle SELECT fall back to READY.
module charge_ctrl
  import charge_pkg::*;
#(
  parameter int CHG_W         = DEF_CHG_W,
  parameter int UNIT_FEE      = DEF_UNIT_FEE,
  parameter int MAX_UNITS     = DEF_MAX_UNITS,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int TIME_FEE      = DEF_TIME_FEE,
  parameter int BASE_FEE      = DEF_BASE_FEE,
  parameter int PLAN1_FEE     = DEF_PLAN1_FEE,
  parameter int PLAN2_FEE     = DEF_PLAN2_FEE,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signal,
  input  logic             sel_unit,
  input  logic             sel_time,
  input  logic             unit_pulse,
  input  logic             plan1,
  input  logic             plan2,
  input  logic             cancel,
  output logic             work,
  output logic             hold_in,
  output logic [1:0]       mode,
  output logic [2:0]       state,
  output logic [CHG_W-1:0] charge,
  output logic             fin
);

  // Fee sums are formed this wide so no product or sum can overflow before clamping.
  localparam int UNIT_W = $clog2(MAX_UNITS + 1);
  localparam int SUM_W  = CHG_W + 33;
  localparam logic [SUM_W-1:0] CHG_MAX     = {{33{1'b0}}, {CHG_W{1'b1}}};
  localparam logic [SUM_W-1:0] UNIT_FEE_W  = SUM_W'(UNIT_FEE);
  localparam logic [SUM_W-1:0] TIME_FEE_W  = SUM_W'(TIME_FEE);
  localparam logic [SUM_W-1:0] BASE_FEE_W  = SUM_W'(BASE_FEE);
  localparam logic [SUM_W-1:0] PLAN1_FEE_W = SUM_W'(PLAN1_FEE);
  localparam logic [SUM_W-1:0] PLAN2_FEE_W = SUM_W'(PLAN2_FEE);
  localparam logic [UNIT_W-1:0] UNITS_END  = UNIT_W'(MAX_UNITS);

  function automatic logic [CHG_W-1:0] clamp_fee(input logic [SUM_W-1:0] v);
    if (v > CHG_MAX) begin
      clamp_fee = CHG_MAX[CHG_W-1:0];
    end else begin
      clamp_fee = v[CHG_W-1:0];
    end
  endfunction

  state_t             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic               work_q, work_d;
  logic               hold_q, hold_d;
  logic               fin_q, fin_d;
  logic [CHG_W-1:0]   charge_q, charge_d;
  logic [UNIT_W-1:0]  units_q, units_d;
  logic [CHG_W-1:0]   elapsed_q, elapsed_d;
  logic               clr_s;
  logic               tick_s;
  logic [UNIT_W-1:0]  units_inc_s;
  logic [CHG_W-1:0]   unit_fee_s;
  logic [CHG_W-1:0]   time_fee_s;
`ifdef CHARGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

  assign units_inc_s = units_q + UNIT_W'(1);
  assign unit_fee_s  = clamp_fee(SUM_W'(units_inc_s) * UNIT_FEE_W);
  assign time_fee_s  = clamp_fee(BASE_FEE_W + SUM_W'(elapsed_q) * TIME_FEE_W);

  // The prescaler runs only while waiting in SELECT or timing a session;
  // leaving SELECT restarts it so a timed session begins at a tick boundary.
  always_comb begin
    clr_s = 1'b1;
    if (state_q == ST_SELECT) begin
      clr_s = sel_unit | sel_time | cancel;
    end else if ((state_q == ST_CHARGE) && (mode_q == MODE_TIME)) begin
      clr_s = 1'b0;
    end else begin
      clr_s = 1'b1;
    end
  end

  charge_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next-state and next-output computation for the session FSM.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    work_d    = work_q;
    hold_d    = hold_q;
    fin_d     = 1'b0;
    charge_d  = charge_q;
    units_d   = units_q;
    elapsed_d = elapsed_q;
`ifdef CHARGE_TIMEOUT_EN
    to_cnt_d  = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READY;
          work_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READY: begin
        if (signal) begin
          state_d  = ST_SELECT;
          hold_d   = 1'b1;
          charge_d = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_SELECT: begin
        if (sel_unit) begin
          state_d = ST_CHARGE;
          mode_d  = MODE_UNIT;
          units_d = '0;
        end else if (sel_time) begin
          state_d   = ST_CHARGE;
          mode_d    = MODE_TIME;
          elapsed_d = '0;
        end else if (cancel) begin
          state_d = ST_READY;
          hold_d  = 1'b0;
        end else begin
`ifdef CHARGE_TIMEOUT_EN
          if (tick_s && (to_cnt_q == TO_LAST)) begin
            state_d = ST_READY;
            hold_d  = 1'b0;
          end else if (tick_s) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end else begin
            to_cnt_d = to_cnt_q;
          end
`else
          state_d = ST_SELECT;
`endif
        end
      end
      ST_CHARGE: begin
        case (mode_q)
          MODE_UNIT: begin
            if (unit_pulse) begin
              units_d  = units_inc_s;
              charge_d = unit_fee_s;
            end else begin
              units_d = units_q;
            end
            if ((unit_pulse && (units_inc_s == UNITS_END)) || cancel) begin
              state_d = ST_DONE;
              fin_d   = 1'b1;
              hold_d  = 1'b0;
              mode_d  = MODE_NONE;
            end else begin
              state_d = ST_CHARGE;
            end
          end
          MODE_TIME: begin
            if (tick_s && (elapsed_q != {CHG_W{1'b1}})) begin
              elapsed_d = elapsed_q + CHG_W'(1);
            end else begin
              elapsed_d = elapsed_q;
            end
            if (cancel) begin
              charge_d = time_fee_s;
            end else if (plan1) begin
              charge_d = clamp_fee(PLAN1_FEE_W);
            end else if (plan2) begin
              charge_d = clamp_fee(PLAN2_FEE_W);
            end else begin
              charge_d = charge_q;
            end
            if (cancel || plan1 || plan2) begin
              state_d = ST_DONE;
              fin_d   = 1'b1;
              hold_d  = 1'b0;
              mode_d  = MODE_NONE;
            end else begin
              state_d = ST_CHARGE;
            end
          end
          default: begin
            // A charge session without a tariff cannot be billed; drop it.
            state_d = ST_READY;
            hold_d  = 1'b0;
            mode_d  = MODE_NONE;
          end
        endcase
      end
      ST_DONE: begin
        state_d = ST_READY;
      end
      default: begin
        state_d  = ST_IDLE;
        mode_d   = MODE_NONE;
        work_d   = 1'b0;
        hold_d   = 1'b0;
        charge_d = '0;
      end
    endcase
  end

  // Session state and registered outputs; reset discards any open session.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_NONE;
      work_q    <= 1'b0;
      hold_q    <= 1'b0;
      fin_q     <= 1'b0;
      charge_q  <= '0;
      units_q   <= '0;
      elapsed_q <= '0;
`ifdef CHARGE_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      work_q    <= work_d;
      hold_q    <= hold_d;
      fin_q     <= fin_d;
      charge_q  <= charge_d;
      units_q   <= units_d;
      elapsed_q <= elapsed_d;
`ifdef CHARGE_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign state   = state_q;
  assign mode    = mode_q;
  assign work    = work_q;
  assign hold_in = hold_q;
  assign fin     = fin_q;
  assign charge  = charge_q;

endmodule

// File: tb/tb_charge_ctrl.sv
// Self-checking bench for charge_ctrl. Two instances share the stimulus:
// a nominal one (8-bit charge, unit fee 1) and a narrow one (4-bit charge,
// unit fee 3) whose fees clamp. Expected fees come from tariff arithmetic.
module tb_charge_ctrl;

  logic clk = 1'b0;
  logic reset, start, signal, sel_unit, sel_time, unit_pulse, plan1, plan2, cancel;
  logic       work_m, hold_m, fin_m, work_s, hold_s, fin_s;
  logic [1:0] mode_m, mode_s;
  logic [2:0] state_m, state_s;
  logic [7:0] charge_m;
  logic [3:0] charge_s;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  charge_ctrl #(.CHG_W(8), .UNIT_FEE(1), .MAX_UNITS(15), .TICK_DIV(4), .TIME_FEE(1),
                .BASE_FEE(10), .PLAN1_FEE(12), .PLAN2_FEE(5), .TIMEOUT_TICKS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .signal(signal), .sel_unit(sel_unit),
    .sel_time(sel_time), .unit_pulse(unit_pulse), .plan1(plan1), .plan2(plan2),
    .cancel(cancel), .work(work_m), .hold_in(hold_m), .mode(mode_m), .state(state_m),
    .charge(charge_m), .fin(fin_m));

  charge_ctrl #(.CHG_W(4), .UNIT_FEE(3), .MAX_UNITS(15), .TICK_DIV(4), .TIME_FEE(1),
                .BASE_FEE(10), .PLAN1_FEE(12), .PLAN2_FEE(5), .TIMEOUT_TICKS(2)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .signal(signal), .sel_unit(sel_unit),
    .sel_time(sel_time), .unit_pulse(unit_pulse), .plan1(plan1), .plan2(plan2),
    .cancel(cancel), .work(work_s), .hold_in(hold_s), .mode(mode_s), .state(state_s),
    .charge(charge_s), .fin(fin_s));

  function automatic int clampw(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    start = 1'b0; signal = 1'b0; sel_unit = 1'b0; sel_time = 1'b0;
    unit_pulse = 1'b0; plan1 = 1'b0; plan2 = 1'b0; cancel = 1'b0;
  endtask

  // Random strobes that the current CHARGE tariff must ignore.
  task automatic noise(input bit time_mode);
    start    = 1'($urandom_range(0, 1));
    signal   = 1'($urandom_range(0, 1));
    sel_unit = 1'($urandom_range(0, 1));
    sel_time = 1'($urandom_range(0, 1));
    if (time_mode) begin
      unit_pulse = 1'($urandom_range(0, 1));
    end else begin
      plan1 = 1'($urandom_range(0, 1));
      plan2 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int wk, input int hi,
                         input int md, input int fn, input int cm, input int cs);
    chk({tag, ".state"},   32'(state_m),  st);
    chk({tag, ".work"},    32'(work_m),   wk);
    chk({tag, ".hold_in"}, 32'(hold_m),   hi);
    chk({tag, ".mode"},    32'(mode_m),   md);
    chk({tag, ".fin"},     32'(fin_m),    fn);
    chk({tag, ".charge"},  32'(charge_m), cm);
    chk({tag, ".state_s"}, 32'(state_s),  st);
    chk({tag, ".fin_s"},   32'(fin_s),    fn);
    chk({tag, ".charge_s"},32'(charge_s), cs);
  endtask

  // UNIT session of n pulses from READY. cmode: 0 separate cancel,
  // 1 cancel together with the last pulse, 2 random choice.
  task automatic run_unit(input int n, input int cmode, input string tag);
    bit with_last;
    int gap;
    with_last = (cmode == 2) ? 1'($urandom_range(0, 1)) : (cmode == 1);
    signal = 1'b1; step(); clear_in();
    chk_all({tag, ".select"}, 2, 1, 1, 0, 0, 0, 0);
    sel_unit = 1'b1; sel_time = 1'($urandom_range(0, 1)); step(); clear_in();
    chk_all({tag, ".enter"}, 3, 1, 1, 1, 0, 0, 0);
    for (int i = 1; i <= n; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        noise(1'b0); step(); clear_in();
        chk({tag, ".gap_state"}, 32'(state_m), 3);
        chk({tag, ".gap_charge"}, 32'(charge_m), clampw(i - 1, 8));
      end
      noise(1'b0); unit_pulse = 1'b1;
      if (i == n && with_last) cancel = 1'b1;
      step(); clear_in();
      if (i == n && (n == 15 || with_last))
        chk_all({tag, ".done"}, 4, 1, 0, 0, 1, clampw(i, 8), clampw(3 * i, 4));
      else
        chk_all({tag, ".pulse"}, 3, 1, 1, 1, 0, clampw(i, 8), clampw(3 * i, 4));
    end
    if (!(n == 15 || with_last)) begin
      noise(1'b0); cancel = 1'b1; step(); clear_in();
      chk_all({tag, ".done"}, 4, 1, 0, 0, 1, clampw(n, 8), clampw(3 * n, 4));
    end
    step();
    chk_all({tag, ".ready"}, 1, 1, 0, 0, 0, clampw(n, 8), clampw(3 * n, 4));
  endtask

  // TIME session from READY: k cycles in CHARGE, then exit kind
  // 0 cancel, 1 plan1, 2 plan2. Ticks elapsed before the exit cycle = k/4.
  task automatic run_time(input int k, input int kind, input string tag);
    int ticks, em, es;
    signal = 1'b1; step(); clear_in();
    chk_all({tag, ".select"}, 2, 1, 1, 0, 0, 0, 0);
    sel_time = 1'b1; step(); clear_in();
    chk_all({tag, ".enter"}, 3, 1, 1, 2, 0, 0, 0);
    for (int j = 0; j < k; j++) begin
      noise(1'b1); step(); clear_in();
      if (j % 16 == 0) chk({tag, ".run_state"}, 32'(state_m), 3);
    end
    ticks = k / 4;
    unit_pulse = 1'($urandom_range(0, 1));
    if (kind == 0) begin
      cancel = 1'b1; plan1 = 1'($urandom_range(0, 1)); plan2 = 1'($urandom_range(0, 1));
      em = clampw(10 + ((ticks > 255) ? 255 : ticks), 8);
      es = clampw(10 + ticks, 4);
    end else if (kind == 1) begin
      plan1 = 1'b1; plan2 = 1'($urandom_range(0, 1));
      em = 12; es = 12;
    end else begin
      plan2 = 1'b1;
      em = 5; es = 5;
    end
    step(); clear_in();
    chk_all({tag, ".done"}, 4, 1, 0, 0, 1, em, es);
    step();
    chk_all({tag, ".ready"}, 1, 1, 0, 0, 0, em, es);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    reset = 1'b1;
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    signal = 1'b1; sel_unit = 1'b1; cancel = 1'b1; plan1 = 1'b1; step(); clear_in();
    chk_all("idle_ignore", 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1; step(); clear_in();
    chk_all("start", 1, 1, 0, 0, 0, 0, 0);
    start = 1'b1; sel_unit = 1'b1; cancel = 1'b1; plan2 = 1'b1; unit_pulse = 1'b1;
    step(); clear_in();
    chk_all("ready_ignore", 1, 1, 0, 0, 0, 0, 0);

    run_unit(3, 0, "basic3");
    run_unit(15, 0, "max15");
    run_unit(6, 1, "sat6");
    repeat (4) run_unit(int'($urandom_range(1, 15)), 2, "rnd_unit");

    run_time(20, 0, "time5");
    run_time(9, 1, "plan1");
    run_time(3, 2, "plan2");
    run_time(0, 0, "time0");
    repeat (4) run_time(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), "rnd_time");
    run_time(1100, 0, "time_sat");

    signal = 1'b1; step(); clear_in();
    chk_all("sel_cancel.select", 2, 1, 1, 0, 0, 0, 0);
    cancel = 1'b1; plan1 = 1'b1; step(); clear_in();
    chk_all("sel_cancel.ready", 1, 1, 0, 0, 0, 0, 0);

    signal = 1'b1; step(); clear_in();
    sel_unit = 1'b1; step(); clear_in();
    unit_pulse = 1'b1; step(); step(); clear_in();
    chk_all("mid.pulses", 3, 1, 1, 1, 0, 2, 6);
    reset = 1'b1; unit_pulse = 1'b1; cancel = 1'b1; step(); clear_in(); reset = 1'b0;
    chk_all("mid.reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    chk_all("mid.after", 0, 0, 0, 0, 0, 0, 0);

    start = 1'b1; step(); clear_in();
    signal = 1'b1; step(); clear_in();
    chk_all("to.select", 2, 1, 1, 0, 0, 0, 0);
`ifdef CHARGE_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      step();
      chk("to.wait_state", 32'(state_m), 2);
    end
    step();
    chk_all("to.expired", 1, 1, 0, 0, 0, 0, 0);
`else
    for (int c = 1; c < 40; c++) begin
      step();
      chk("to.wait_state", 32'(state_m), 2);
    end
    cancel = 1'b1; step(); clear_in();
    chk_all("to.cancel", 1, 1, 0, 0, 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
